// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// Optional build macro LOGIC_UNIT_PIPE_REDUCE_EN adds red_or/red_and.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic [CNT_W-1:0] op_count;
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    logic             red_or;
    logic             red_and;
`endif

    modport master (
        output in_valid, a, b, op, out_ready,
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
        input  red_or, red_and,
`endif
        input  in_ready, out_valid, y, zero, op_count
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
        output red_or, red_and,
`endif
        output in_ready, out_valid, y, zero, op_count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// WIDTH-bit 8-op bitwise logic unit feeding a STAGES-deep valid/ready pipeline.
// Build macro LOGIC_UNIT_PIPE_REDUCE_EN adds registered red_or/red_and outputs.
module logic_unit_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    logic_unit_pipe_if.slave bus
);
    logic [WIDTH-1:0]             res;
    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0]            zero_q, zero_d;
    logic [STAGES-1:0]            stage_rdy;
    logic [STAGES-1:0][WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0]             op_count_q, op_count_d;
    logic                         out_xfer;
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    logic [STAGES-1:0]            red_or_q, red_or_d;
    logic [STAGES-1:0]            red_and_q, red_and_d;
`endif

    always_comb begin
        case (bus.op)
            3'b000:  res = bus.a & bus.b;
            3'b001:  res = bus.a | bus.b;
            3'b010:  res = bus.a ^ bus.b;
            3'b011:  res = ~(bus.a & bus.b);
            3'b100:  res = ~(bus.a | bus.b);
            3'b101:  res = ~(bus.a ^ bus.b);
            3'b110:  res = ~bus.a;
            default: res = bus.a;
        endcase
    end

    // Unrolled ready chain: a stage can take data if it or any stage after it is empty.
    for (genvar k = 0; k < STAGES; k++) begin : g_rdy
        assign stage_rdy[k] = bus.out_ready | ~(&valid_q[STAGES-1:k]);
    end

    assign out_xfer = valid_q[STAGES-1] & bus.out_ready;

    always_comb begin
        valid_d    = valid_q;
        y_d        = y_q;
        zero_d     = zero_q;
        op_count_d = op_count_q;
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
        red_or_d   = red_or_q;
        red_and_d  = red_and_q;
`endif
        if (stage_rdy[0]) begin
            valid_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                y_d[0]    = res;
                zero_d[0] = (res == '0);
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
                red_or_d[0]  = |res;
                red_and_d[0] = &res;
`endif
            end
        end
        // Data registers only move on a real item so the last stage keeps its value after draining.
        for (int k = 1; k < STAGES; k++) begin
            if (stage_rdy[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    y_d[k]    = y_q[k-1];
                    zero_d[k] = zero_q[k-1];
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
                    red_or_d[k]  = red_or_q[k-1];
                    red_and_d[k] = red_and_q[k-1];
`endif
                end
            end
        end
        if (out_xfer) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            y_q        <= '0;
            zero_q     <= '0;
            op_count_q <= '0;
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
            red_or_q   <= '0;
            red_and_q  <= '0;
`endif
        end else begin
            valid_q    <= valid_d;
            y_q        <= y_d;
            zero_q     <= zero_d;
            op_count_q <= op_count_d;
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
            red_or_q   <= red_or_d;
            red_and_q  <= red_and_d;
`endif
        end
    end

    assign bus.in_ready  = ~rst & stage_rdy[0];
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.y         = y_q[STAGES-1];
    assign bus.zero      = zero_q[STAGES-1];
    assign bus.op_count  = op_count_q;
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    assign bus.red_or    = red_or_q[STAGES-1];
    assign bus.red_and   = red_and_q[STAGES-1];
`endif
endmodule
